mult_result_accumulator: RTL and testbench

MULT_RESULT_ACCUMULATOR -- requirements
Module: mult_result_accumulator

---
 rtl/mult_acc_pkg.sv | 16 +
 rtl/done_rise_det.sv | 19 +
 rtl/mult_result_accumulator.sv | 115 +++++++++++
 tb/tb_mult_result_accumulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the multiplier-result accumulator.
package mult_acc_pkg;

  localparam int unsigned N_PRODUCTS_DEF = 4;
  localparam int unsigned ACC_W_DEF      = 24;
  localparam int unsigned PROD_W         = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ADD,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/done_rise_det.sv
// Registers the multiplier DONE level and flags its rising edge.
module done_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic done_i,
  output logic rise_o
);

  logic done_q;

  // DONE delayed by one cycle, tracked in every state
  always_ff @(posedge clk_i) begin
    if (rst_i) done_q <= 1'b0;
    else       done_q <= done_i;
  end

  assign rise_o = done_i & ~done_q;

endmodule

// File: rtl/mult_result_accumulator.sv
// Accumulates a batch of N_PRODUCTS multiplier results into acc.
// Optional build macro ACC_SAT_EN: saturate acc to all-ones on overflow
// instead of wrapping modulo 2^ACC_W.
module mult_result_accumulator
  import mult_acc_pkg::*;
#(
  parameter int unsigned N_PRODUCTS = N_PRODUCTS_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  input  logic [PROD_W-1:0] result,
  input  logic              DONE,
  output logic              start_next,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_valid,
  output logic [7:0]        count,
  output logic              ovf,
  output logic              busy
);

  localparam logic [7:0] N_LAST = 8'(N_PRODUCTS);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [7:0]          count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                rise;
  logic [ACC_W:0]      sum;
  logic [7:0]          count_inc;

  done_rise_det u_rise (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .done_i (DONE),
    .rise_o (rise)
  );

  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
  assign count_inc = count_q + 8'd1;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
    end
  end

  // Next-state, datapath update and state-decoded strobes
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    prod_d     = prod_q;
    start_next = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (en) begin
          state_d = S_REQ;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_REQ: begin
        start_next = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (rise) begin
          prod_d  = result;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        count_d = count_inc;
        if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef ACC_SAT_EN
        // once overflowed, stay pinned even if a later product is zero
        if (sum[ACC_W] || ovf_q) acc_d = '1;
        else                     acc_d = sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
        state_d = (count_inc == N_LAST) ? S_FLUSH : S_REQ;
      end
      S_FLUSH: begin
        acc_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign acc   = acc_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Directed self-checking bench for mult_result_accumulator.
module tb_mult_result_accumulator;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        en = 1'b0;
  logic        DONE = 1'b0;
  logic [15:0] result = '0;

  always #5 CLK = ~CLK;

  // dut0: defaults (4 products, 24-bit acc)
  logic        sn0, av0, ovf0, busy0;
  logic [23:0] acc0;
  logic [7:0]  count0;
  // dut1: 3 products, 17-bit acc
  logic        sn1, av1, ovf1, busy1;
  logic [16:0] acc1;
  logic [7:0]  count1;
  // dut2: single product, 24-bit acc
  logic        sn2, av2, ovf2, busy2;
  logic [23:0] acc2;
  logic [7:0]  count2;

  mult_result_accumulator #(.N_PRODUCTS(4), .ACC_W(24)) dut0 (
    .CLK(CLK), .RESET(RESET), .en(en), .result(result), .DONE(DONE),
    .start_next(sn0), .acc(acc0), .acc_valid(av0), .count(count0),
    .ovf(ovf0), .busy(busy0)
  );

  mult_result_accumulator #(.N_PRODUCTS(3), .ACC_W(17)) dut1 (
    .CLK(CLK), .RESET(RESET), .en(en), .result(result), .DONE(DONE),
    .start_next(sn1), .acc(acc1), .acc_valid(av1), .count(count1),
    .ovf(ovf1), .busy(busy1)
  );

  mult_result_accumulator #(.N_PRODUCTS(1), .ACC_W(24)) dut2 (
    .CLK(CLK), .RESET(RESET), .en(en), .result(result), .DONE(DONE),
    .start_next(sn2), .acc(acc2), .acc_valid(av2), .count(count2),
    .ovf(ovf2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int sn_cnt0 = 0;
  int sel = 0;
  logic sn_sel;

  always_comb begin
    sn_sel = sn0;
    if (sel == 1) sn_sel = sn1;
    else if (sel == 2) sn_sel = sn2;
  end

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    if (sn0) sn_cnt0++;
    @(posedge CLK);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    RESET = 1'b1; en = 1'b0; DONE = 1'b0;
    cyc(); cyc();
    RESET = 1'b0;
    sn_cnt0 = 0;
  endtask

  // wait for start_next of the selected dut, raise DONE dly cycles later
  task automatic feed(input int dly);
    int t = 0;
    while (!sn_sel && t < 30) begin cyc(); t++; end
    if (!sn_sel) begin
      checks++; errors++;
      $display("FAIL feed_timeout start_next got 0 exp 1 (dut %0d)", sel);
    end
    repeat (dly) cyc();
    DONE = 1'b1;
    cyc();
    DONE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; en = 1'b1; DONE = 1'b1;
    cyc();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy0); end
    checks++; if (acc0 !== 24'd0) begin errors++; $display("FAIL reset_acc got %0d exp 0", acc0); end
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
    checks++; if ({ovf0, sn0, av0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %03b exp 000", {ovf0, sn0, av0}); end
    en = 1'b0; DONE = 1'b0;
    cyc();
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    sel = 0; do_reset(); result = 16'd350;
    en = 1'b1; cyc(); en = 1'b0;
    repeat (4) feed(2);
    cyc();
    checks++; if (av0 !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", av0); end
    checks++; if (acc0 !== 24'd1400) begin errors++; $display("FAIL basic_acc got %0d exp 1400", acc0); end
    checks++; if (count0 !== 8'd4 || ovf0 !== 1'b0) begin errors++; $display("FAIL basic_count_ovf got %0d/%0b exp 4/0", count0, ovf0); end
    checks++; if (sn_cnt0 !== 4) begin errors++; $display("FAIL basic_start_pulses got %0d exp 4", sn_cnt0); end
    cyc();
    checks++; if (av0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL basic_idle got valid=%0b busy=%0b exp 0/0", av0, busy0); end
    checks++; if (acc0 !== 24'd1400) begin errors++; $display("FAIL basic_hold got %0d exp 1400", acc0); end
  endtask

  task automatic test_done_held();
    sel = 0; do_reset(); result = 16'd350;
    en = 1'b1; cyc(); en = 1'b0;
    cyc();
    DONE = 1'b1;
    repeat (10) cyc();
    checks++; if (count0 !== 8'd1) begin errors++; $display("FAIL held_count got %0d exp 1", count0); end
    checks++; if (busy0 !== 1'b1 || sn_cnt0 !== 2) begin errors++; $display("FAIL held_stall got busy=%0b starts=%0d exp 1/2", busy0, sn_cnt0); end
    DONE = 1'b0; cyc();
    DONE = 1'b1; cyc();
    DONE = 1'b0; cyc();
    checks++; if (count0 !== 8'd2 || acc0 !== 24'd700) begin errors++; $display("FAIL held_retoggle got %0d/%0d exp 2/700", count0, acc0); end
  endtask

  task automatic test_overflow();
    logic [16:0] exp_acc;
`ifdef ACC_SAT_EN
    exp_acc = 17'd131071;
`else
    exp_acc = 17'd64003;
`endif
    sel = 1; do_reset(); result = 16'd65025;
    en = 1'b1; cyc(); en = 1'b0;
    feed(1); feed(1);
    cyc();
    checks++; if (acc1 !== 17'd130050 || ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_mid got %0d/%0b exp 130050/0", acc1, ovf1); end
    feed(1);
    cyc();
    checks++; if (av1 !== 1'b1 || count1 !== 8'd3) begin errors++; $display("FAIL ovf_valid got %0b/%0d exp 1/3", av1, count1); end
    checks++; if (acc1 !== exp_acc) begin errors++; $display("FAIL ovf_acc got %0d exp %0d", acc1, exp_acc); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ovf1); end
    cyc();
    checks++; if (ovf1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL ovf_sticky got %0b/%0b exp 1/0", ovf1, busy1); end
    en = 1'b1; cyc(); en = 1'b0;
    checks++; if (ovf1 !== 1'b0 || acc1 !== 17'd0 || count1 !== 8'd0) begin errors++; $display("FAIL ovf_clear got %0b/%0d/%0d exp 0/0/0", ovf1, acc1, count1); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    sel = 0; do_reset(); result = 16'd350;
    en = 1'b1; cyc(); en = 1'b0;
    feed(1); feed(1);
    RESET = 1'b1; cyc(); RESET = 1'b0;
    checks++; if (busy0 !== 1'b0 || acc0 !== 24'd0 || count0 !== 8'd0 || sn0 !== 1'b0) begin errors++; $display("FAIL midrst_state got busy=%0b acc=%0d cnt=%0d sn=%0b exp 0/0/0/0", busy0, acc0, count0, sn0); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (av0) seen = 1'b1;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got 1 exp 0"); end
    sn_cnt0 = 0;
    en = 1'b1; cyc(); en = 1'b0;
    repeat (4) feed(3);
    cyc();
    checks++; if (av0 !== 1'b1 || acc0 !== 24'd1400 || count0 !== 8'd4) begin errors++; $display("FAIL midrst_rerun got %0b/%0d/%0d exp 1/1400/4", av0, acc0, count0); end
  endtask

  task automatic test_ignored();
    sel = 0; do_reset(); result = 16'd350;
    DONE = 1'b1; cyc(); DONE = 1'b0; cyc();
    checks++; if (busy0 !== 1'b0 || count0 !== 8'd0 || sn_cnt0 !== 0) begin errors++; $display("FAIL ign_idle_done got busy=%0b cnt=%0d starts=%0d exp 0/0/0", busy0, count0, sn_cnt0); end
    en = 1'b1; cyc(); en = 1'b0;
    cyc();
    en = 1'b1; cyc(); en = 1'b0;
    checks++; if (count0 !== 8'd0 || busy0 !== 1'b1 || sn_cnt0 !== 1 || sn0 !== 1'b0) begin errors++; $display("FAIL ign_wait_en got cnt=%0d busy=%0b starts=%0d sn=%0b exp 0/1/1/0", count0, busy0, sn_cnt0, sn0); end
    DONE = 1'b1; cyc(); DONE = 1'b0;
    cyc();
    checks++; if (count0 !== 8'd1 || acc0 !== 24'd350 || sn0 !== 1'b1) begin errors++; $display("FAIL ign_resume got cnt=%0d acc=%0d sn=%0b exp 1/350/1", count0, acc0, sn0); end
  endtask

  task automatic test_single();
    int start;
    sel = 2; do_reset(); result = 16'd65535;
    start = cyc_no;
    en = 1'b1; cyc(); en = 1'b0;
    feed(1);
    checks++; if (av2 !== 1'b0) begin errors++; $display("FAIL n1_early_valid got 1 exp 0"); end
    cyc();
    checks++; if (av2 !== 1'b1 || (cyc_no - start) !== 4) begin errors++; $display("FAIL n1_latency got valid=%0b after %0d cycles exp 1 after 4", av2, cyc_no - start); end
    checks++; if (acc2 !== 24'd65535 || count2 !== 8'd1 || ovf2 !== 1'b0) begin errors++; $display("FAIL n1_acc got %0d/%0d/%0b exp 65535/1/0", acc2, count2, ovf2); end
    cyc();
    checks++; if (busy2 !== 1'b0 || av2 !== 1'b0) begin errors++; $display("FAIL n1_idle got busy=%0b valid=%0b exp 0/0", busy2, av2); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_done_held();
    test_overflow();
    test_reset_mid();
    test_ignored();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, exp finish before time limit");
    $fatal(1);
  end

endmodule
